// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern table, pattern decoder and reader FSM states
package seg7_pkg;

  // Active-low patterns, bit order g..a (bit0 = a)
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Returns {legal, nibble}; illegal patterns yield 5'b0_0000
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      SEG_0: r = 5'h10;
      SEG_1: r = 5'h11;
      SEG_2: r = 5'h12;
      SEG_3: r = 5'h13;
      SEG_4: r = 5'h14;
      SEG_5: r = 5'h15;
      SEG_6: r = 5'h16;
      SEG_7: r = 5'h17;
      SEG_8: r = 5'h18;
      SEG_9: r = 5'h19;
      SEG_A: r = 5'h1A;
      SEG_B: r = 5'h1B;
      SEG_C: r = 5'h1C;
      SEG_D: r = 5'h1D;
      SEG_E: r = 5'h1E;
      SEG_F: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterised-width two-flop synchroniser with configurable reset value
module sync_2ff #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values of the two stages: plain shift
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - multiplexed 7-segment bus reader; optional decimal point via SEG7_READER_DP_EN
module seg7_reader
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 16,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
`ifdef SEG7_READER_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp_o,
`endif
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic [NUM_DIGITS-1:0]   invalid_o,
  output logic                    update_o,
  output logic [IDX_W-1:0]        update_idx_o
);

`ifdef SEG7_READER_DP_EN
  localparam int SW = 8 + NUM_DIGITS;
  logic [SW-1:0] pins;
  assign pins = {dp_n, dig_n, seg_n};
`else
  localparam int SW = 7 + NUM_DIGITS;
  logic [SW-1:0] pins;
  assign pins = {dig_n, seg_n};
`endif

  logic [SW-1:0]         smp;
  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] dig_s;

  sync_2ff #(.W(SW), .RST_VAL({SW{1'b1}})) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pins),
    .q    (smp)
  );

  assign seg_s = smp[6:0];
  assign dig_s = smp[7 +: NUM_DIGITS];

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]           prev_q, prev_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
  logic                    update_q, update_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    commit, match, sel_ok, changed;
  logic [4:0]              dec;
  logic [IDX_W-1:0]        sel_idx;
`ifdef SEG7_READER_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

  // Stability FSM: commit once a one-hot selection has been steady for STABLE_CYCLES samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = smp;
    commit  = 1'b0;
    match   = (smp == prev_q);
    sel_ok  = $onehot(~dig_s);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_ok) state_d = SETTLE;
      end
      SETTLE: begin
        if (!match) begin
          cnt_d   = '0;
          state_d = sel_ok ? SETTLE : IDLE;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          commit  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!match) begin
          cnt_d   = '0;
          state_d = sel_ok ? SETTLE : IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Register bank update; update pulse only when visible state of the digit changes
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    update_d  = 1'b0;
    idx_d     = idx_q;
    changed   = 1'b0;
    dec       = seg_to_nibble(seg_s);
    sel_idx   = '0;
`ifdef SEG7_READER_DP_EN
    dp_d      = dp_q;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_s[i]) sel_idx = IDX_W'(i);
    end
    if (commit) begin
      if (dec[4]) begin
        changed = (digits_q[4*sel_idx +: 4] != dec[3:0]) || invalid_q[sel_idx];
        digits_d[4*sel_idx +: 4] = dec[3:0];
        valid_d[sel_idx]   = 1'b1;
        invalid_d[sel_idx] = 1'b0;
      end else begin
        changed = !invalid_q[sel_idx];
        invalid_d[sel_idx] = 1'b1;
      end
`ifdef SEG7_READER_DP_EN
      changed = changed || (dp_q[sel_idx] != ~smp[SW-1]);
      dp_d[sel_idx] = ~smp[SW-1];
`endif
      if (changed) begin
        update_d = 1'b1;
        idx_d    = sel_idx;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= '1;
      digits_q  <= '0;
      valid_q   <= '0;
      invalid_q <= '0;
      update_q  <= 1'b0;
      idx_q     <= '0;
`ifdef SEG7_READER_DP_EN
      dp_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      update_q  <= update_d;
      idx_q     <= idx_d;
`ifdef SEG7_READER_DP_EN
      dp_q      <= dp_d;
`endif
    end
  end

  assign digits_o      = digits_q;
  assign digit_valid_o = valid_q;
  assign invalid_o     = invalid_q;
  assign update_o      = update_q;
  assign update_idx_o  = idx_q;
`ifdef SEG7_READER_DP_EN
  assign dp_o          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - scoreboard bench for seg7_reader (4 digits, 16-cycle settle)
module tb_seg7_reader;
  import seg7_pkg::*;

  localparam int LAT = 16 + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] digits_o;
  logic [3:0]  digit_valid_o;
  logic [3:0]  invalid_o;
  logic        update_o;
  logic [1:0]  update_idx_o;
`ifdef SEG7_READER_DP_EN
  logic        dp_n = 1'b1;
  logic [3:0]  dp_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic       inv;
    logic [3:0] nib;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  seg7_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .dig_n        (dig_n),
`ifdef SEG7_READER_DP_EN
    .dp_n         (dp_n),
    .dp_o         (dp_o),
`endif
    .digits_o     (digits_o),
    .digit_valid_o(digit_valid_o),
    .invalid_o    (invalid_o),
    .update_o     (update_o),
    .update_idx_o (update_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic inv, input logic [3:0] nib);
    exp_t x;
    x.idx = idx;
    x.inv = inv;
    x.nib = nib;
    exp_q.push_back(x);
  endtask

  task automatic show(input logic [3:0] d, input logic [6:0] s, input int cycles);
    dig_n = d;
    seg_n = s;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!update_o && n < 40);
    check(name, n, LAT);
  endtask

  // Monitor: every update pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (rst_n === 1'b1 && update_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: idx %0d with none expected", update_idx_o);
      end else begin
        e = exp_q.pop_front();
        check("upd_idx", update_idx_o, e.idx);
        check("upd_nibble", digits_o[4*e.idx +: 4], e.nib);
        check("upd_invalid", invalid_o[e.idx], e.inv);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    rst_n = 1'b0;
    dig_n = 4'b1111;
    seg_n = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", digits_o, 16'h0000);
    check("rst_valid", digit_valid_o, 4'h0);
    check("rst_invalid", invalid_o, 4'h0);
    check("rst_update", update_o, 1'b0);
    check("rst_idx", update_idx_o, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Digit 0 shows 3; latency from pin change to update pulse
    push(2'd0, 1'b0, 4'h3);
    dig_n = 4'b1110;
    seg_n = 7'b0110000;
    measure_latency("latency_first");
    repeat (30 - LAT) @(posedge clk);
    #1;
    check("t1_nibble", digits_o[3:0], 4'h3);
    check("t1_valid0", digit_valid_o[0], 1'b1);

    // Short glitch on digit 1 must not commit
    show(4'b1101, 7'b1111000, 10);
    show(4'b1111, 7'b1111111, 30);
    check("glitch_digits", digits_o, 16'h0003);
    check("glitch_valid", digit_valid_o, 4'b0001);

    // Scan 1, b, d, F across digits 0..3
    push(2'd0, 1'b0, 4'h1);
    push(2'd1, 1'b0, 4'hB);
    push(2'd2, 1'b0, 4'hD);
    push(2'd3, 1'b0, 4'hF);
    show(4'b1110, 7'b1111001, 40);
    show(4'b1101, 7'b0000011, 40);
    show(4'b1011, 7'b0100001, 40);
    show(4'b0111, 7'b0001110, 40);
    check("scan_digits", digits_o, 16'hFDB1);
    check("scan_valid", digit_valid_o, 4'hF);
    check("scan_invalid", invalid_o, 4'h0);

    // Digit 2: legal 5, then blank (illegal), then 5 again
    push(2'd2, 1'b0, 4'h5);
    show(4'b1011, 7'b0010010, 40);
    push(2'd2, 1'b1, 4'h5);
    show(4'b1011, 7'b1111111, 40);
    check("illegal_inv2", invalid_o[2], 1'b1);
    check("illegal_nib2", digits_o[11:8], 4'h5);
    check("illegal_valid2", digit_valid_o[2], 1'b1);
    push(2'd2, 1'b0, 4'h5);
    show(4'b1011, 7'b0010010, 40);
    check("relegal_inv2", invalid_o[2], 1'b0);

    // Two digits selected: FSM must remain idle
    show(4'b1100, 7'b0010010, 4);
    bad = 0;
    repeat (46) begin
      @(posedge clk);
      #1;
      if (dut.state_q != IDLE) bad++;
    end
    check("multisel_idle_cycles", bad, 0);
    check("multisel_digits", digits_o, 16'hF5B1);

    // Reset in the middle of a settle
    dig_n = 4'b1110;
    seg_n = 7'b1111000;
    n = 0;
    while (!(dut.state_q == SETTLE && dut.cnt_q == 4'd10) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_cnt10", (n < 60), 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_digits", digits_o, 16'h0000);
    check("midrst_valid", digit_valid_o, 4'h0);
    check("midrst_invalid", invalid_o, 4'h0);
    check("midrst_state", dut.state_q, IDLE);
    check("midrst_cnt", dut.cnt_q, 4'd0);
    push(2'd0, 1'b0, 4'h7);
    rst_n = 1'b1;
    measure_latency("latency_after_reset");
    repeat (5) @(posedge clk);
    #1;
    check("postrst_digits", digits_o, 16'h0007);
    check("postrst_valid", digit_valid_o, 4'b0001);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Recovers hex digits from a multiplexed, active-low 7-segment display bus: the inverse of the hex-to-segment encoder. It synchronises the external segment and digit-select lines, and waits for each digit's pattern to be stable. It then decodes the pattern back to a nibble and holds a per-digit register bank for downstream logic. It sits between the board-level display pins (or a sniffed display from another board) and any consumer needing the displayed values.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; range 1..8.
- STABLE_CYCLES, 16: consecutive identical synchronised samples required before a commit; minimum 2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg_n  in  7  segment lines, active-low, bit0 = a … bit6 = g; asynchronous to clk.
- dig_n  in  NUM_DIGITS  digit selects, active-low; asynchronous to clk.
- digits_o  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid_o  out  NUM_DIGITS  digit i has committed at least one legal pattern since reset.
- invalid_o  out  NUM_DIGITS  digit i's most recent commit was an illegal pattern.
- update_o  out  1  one-cycle pulse when any digit's nibble or invalid bit changes.
- update_idx_o  out  max(1,$clog2(NUM_DIGITS))  index of the digit that changed; valid only with update_o.

## Operation
- seg_n and dig_n pass through 2-flop synchronisers. All logic below uses synchronised values.
- The legal patterns use the same table as the encoder (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Any other pattern is illegal.
- FSM:
  - IDLE: no digit selected, or more than one selected. Counter is held at 0. Go to SETTLE when exactly one dig_n bit is low.
  - SETTLE: the counter increments while {seg,dig} equals the previous sample. Any difference reloads the counter to 0 and stays in SETTLE, or goes to IDLE if the selection is no longer one-hot. When the counter reaches STABLE_CYCLES-1 with a matching sample, commit and go to HOLD.
  - HOLD: a committed value is retained. Any change in {seg,dig} goes to SETTLE with counter 0, or to IDLE if the selection is not one-hot. No re-commit occurs while the inputs are unchanged.
- Commit to digit i, legal pattern: nibble = decoded value, digit_valid_o[i]=1, invalid_o[i]=0.
- Commit to digit i, illegal pattern: nibble unchanged, digit_valid_o[i] unchanged, invalid_o[i]=1.
- update_o fires on a commit only if nibble[i] or invalid_o[i] actually changed. A commit that changes nothing is silent.
- Only one digit commits per cycle, by construction.

## Timing
- Reset values: digits_o=0, digit_valid_o=0, invalid_o=0, update_o=0, update_idx_o=0, FSM=IDLE, counter=0, synchronisers=all-ones (no digit selected).
- Latency: the pins must be stable from clock edge t. The commit registers, and update_o is high, in the cycle following edge t+2+STABLE_CYCLES.
- update_o lasts exactly one cycle. Outputs are registered.
- Counter width is $clog2(STABLE_CYCLES) bits and it saturates, so it never wraps.
- A glitch of fewer than STABLE_CYCLES cycles never commits.
- If rst_n asserts mid-settle, all state clears immediately. After deassertion the block starts from IDLE, and the first commit requires a full settle.

## Configuration
- SEG7_READER_DP_EN defined:
  - Adds input dp_n (1 bit, active-low decimal point), synchronised and included in the stability compare.
  - Adds output dp_o[NUM_DIGITS-1:0], which latches the inverted dp_n on every commit to digit i, legal or illegal.
  - A change in dp_o[i] also pulses update_o.
  - dp_o resets to 0.
- SEG7_READER_DP_EN undefined: none of these ports or logic exist.

## Structure
- seg7_pkg:
  - The 16 segment pattern constants, shared with the encoder.
  - A seg_to_nibble function returning {legal, nibble}.
  - The FSM state enum {IDLE, SETTLE, HOLD}.
- Sub-module sync_2ff: parameterised-width 2-flop synchroniser with async active-low reset and a reset-value parameter. It is instantiated once for {dp_n, dig_n, seg_n}.

## Test plan
- Hold dig_n=1110 and seg_n=0110000 for 30 cycles. Expect digits_o[3:0]=3, digit_valid_o[0]=1, and update_o with idx 0 exactly STABLE_CYCLES+3 edges after the change.
- Present a 10-cycle pulse of seg_n=1111000 on digit 1, then return to no selection. Expect no update and digits unchanged.
- Scan four digits for 40 cycles each showing 1,b,d,F. Expect digits_o=16'hFDB1 and four update pulses with idx 0..3 in order.
- On digit 2 after a legal 5, hold seg_n=1111111. Expect invalid_o[2]=1, nibble still 5, one update pulse. Re-present 5: invalid_o[2]=0, one pulse.
- Set dig_n=1100 (two digits selected) for 50 cycles. Expect the FSM to stay in IDLE with no commit.
- Assert rst_n at SETTLE count 10 and deassert it. Expect all outputs 0, then a fresh full-latency commit.
